// File: rtl/spm_bus_arbiter.sv
// rtl/spm_bus_arbiter.sv - SPM arbiter for test, CPU data and CPU fetch ports (optional stats: SPM_ARB_STATS_EN)
module spm_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              test_as_,
  input  logic              test_rw,
  input  logic [ADDR_W-1:0] test_addr,
  input  logic [DATA_W-1:0] test_wr_data,
  output logic [DATA_W-1:0] test_rd_data,
  output logic              test_rdy,
  input  logic              dmem_as_,
  input  logic              dmem_rw,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wr_data,
  output logic [DATA_W-1:0] dmem_rd_data,
  output logic              dmem_rdy,
  input  logic              imem_as_,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_rd_data,
  output logic              imem_rdy,
`ifdef SPM_ARB_STATS_EN
  output logic [15:0]       stat_test_cnt,
  output logic [15:0]       stat_dmem_cnt,
  output logic [15:0]       stat_imem_cnt,
  output logic [15:0]       stat_conflict_cnt,
`endif
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [ADDR_W-1:0] spm_addr,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_TEST, OWN_DMEM, OWN_IMEM} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, next_state;
  owner_t     owner, grant;
  logic       own_rw, grant_rw;
  logic [3:0] starve_cnt, starve_nxt;

  // Requests gated by cpu_en; reset held low suppresses any grant
  logic test_req, dmem_req, imem_req, promote;
  assign test_req = reset & ~test_as_;
  assign dmem_req = reset & cpu_en & ~dmem_as_;
  assign imem_req = reset & cpu_en & ~imem_as_;
  assign promote  = (starve_cnt == LIMIT);

  // State, owner and starvation counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      own_rw     <= 1'b1;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_nxt;
      if (state == IDLE && grant != OWN_NONE) begin
        owner  <= grant;
        own_rw <= grant_rw;
      end else if (state == RESP) begin
        owner  <= OWN_NONE;
        own_rw <= 1'b1;
      end
    end
  end

  // Arbitration, next state and starvation bookkeeping
  always_comb begin
    grant      = OWN_NONE;
    grant_rw   = 1'b1;
    next_state = IDLE;
    starve_nxt = starve_cnt;
    if (state == IDLE) begin
      if (test_req) begin
        grant    = OWN_TEST;
        grant_rw = test_rw;
      end else if (promote && imem_req) begin
        grant    = OWN_IMEM;
      end else if (dmem_req) begin
        grant    = OWN_DMEM;
        grant_rw = dmem_rw;
      end else if (imem_req) begin
        grant    = OWN_IMEM;
      end
      if (grant != OWN_NONE) next_state = RESP;
      // A test win leaves the count alone; a data win over a waiting fetch bumps it
      if (grant == OWN_IMEM) begin
        starve_nxt = '0;
      end else if (grant == OWN_DMEM && imem_req && starve_cnt < LIMIT) begin
        starve_nxt = starve_cnt + 4'd1;
      end
    end
    if (!imem_req) starve_nxt = '0;
  end

  // SPM drive from the winner, ready/read-data return to the owner
  always_comb begin
    spm_as_      = 1'b1;
    spm_rw       = 1'b1;
    spm_addr     = '0;
    spm_wr_data  = '0;
    test_rdy     = 1'b0;
    dmem_rdy     = 1'b0;
    imem_rdy     = 1'b0;
    test_rd_data = '0;
    dmem_rd_data = '0;
    imem_rd_data = '0;
    case (grant)
      OWN_TEST: begin
        spm_as_     = 1'b0;
        spm_rw      = test_rw;
        spm_addr    = test_addr;
        spm_wr_data = test_wr_data;
      end
      OWN_DMEM: begin
        spm_as_     = 1'b0;
        spm_rw      = dmem_rw;
        spm_addr    = dmem_addr;
        spm_wr_data = dmem_wr_data;
      end
      OWN_IMEM: begin
        spm_as_     = 1'b0;
        spm_addr    = imem_addr;
      end
      default: ;
    endcase
    if (state == RESP) begin
      case (owner)
        OWN_TEST: begin
          test_rdy = 1'b1;
          if (own_rw) test_rd_data = spm_rd_data;
        end
        OWN_DMEM: begin
          dmem_rdy = 1'b1;
          if (own_rw) dmem_rd_data = spm_rd_data;
        end
        OWN_IMEM: begin
          imem_rdy     = 1'b1;
          imem_rd_data = spm_rd_data;
        end
        default: ;
      endcase
    end
  end

`ifdef SPM_ARB_STATS_EN
  logic conflict;
  assign conflict = (state == IDLE) &&
                    ((test_req & dmem_req) | (test_req & imem_req) | (dmem_req & imem_req));

  // Wrapping per-port completion and conflict counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_test_cnt     <= '0;
      stat_dmem_cnt     <= '0;
      stat_imem_cnt     <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (test_rdy) stat_test_cnt <= stat_test_cnt + 16'd1;
      if (dmem_rdy) stat_dmem_cnt <= stat_dmem_cnt + 16'd1;
      if (imem_rdy) stat_imem_cnt <= stat_imem_cnt + 16'd1;
      if (conflict) stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
